// File: rtl/midi_tx_pkg.sv
// rtl/midi_tx_pkg.sv - MIDI status codes and transmit FSM encoding shared by the MIDI encoder.
package midi_tx_pkg;

  localparam logic [3:0] S_NOTE_OFF    = 4'h8;
  localparam logic [3:0] S_NOTE_ON     = 4'h9;
  localparam logic [3:0] S_PROG_CHANGE = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATUS = 2'd1,
    ST_DATA1  = 2'd2,
    ST_DATA2  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/register_clr.sv
// rtl/register_clr.sv - load-enabled register with synchronous clear.
module register_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI message encoder: serialises note/program requests into a
// status + data byte stream over a DV/TX_READY handshake, with optional running status.
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [3:0] CHANNEL,
  input  logic [6:0] NOTE_NUM,
  input  logic [6:0] NOTE_VEL,
  input  logic [6:0] PROGRAM,
  input  logic       SEND_NOTE_ON,
  input  logic       SEND_NOTE_OFF,
  input  logic       SEND_PROG,
  output logic       READY,
  output logic [7:0] DATA,
  output logic       DV,
  input  logic       TX_READY
);

  tx_state_e  state_q, state_d;
  logic [7:0] status_q, last_status_q, req_status;
  logic [6:0] d1_q, d2_q, req_d1;
  logic       accept, take, last_en;

  always_comb begin
    req_status = {S_PROG_CHANGE, CHANNEL};
    req_d1     = PROGRAM;
    if (SEND_NOTE_OFF) begin
      req_status = {S_NOTE_OFF, CHANNEL};
      req_d1     = NOTE_NUM;
    end else if (SEND_NOTE_ON) begin
      req_status = {S_NOTE_ON, CHANNEL};
      req_d1     = NOTE_NUM;
    end
  end

  assign accept = CE & (state_q == ST_IDLE) & (SEND_NOTE_OFF | SEND_NOTE_ON | SEND_PROG);
  // DV is high in every non-idle state, so a transfer there only needs CE and TX_READY.
  assign take   = CE & TX_READY;

  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    DV      = 1'b0;
    DATA    = 8'h00;
    last_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        READY = 1'b1;
        if (accept) begin
          if (RUNNING_STATUS && (req_status == last_status_q)) state_d = ST_DATA1;
          else                                                 state_d = ST_STATUS;
        end
      end
      ST_STATUS: begin
        DV   = 1'b1;
        DATA = status_q;
        if (take) begin
          last_en = 1'b1;
          state_d = ST_DATA1;
        end
      end
      ST_DATA1: begin
        DV   = 1'b1;
        DATA = {1'b0, d1_q};
        if (take) state_d = (status_q[7:4] == S_PROG_CHANGE) ? ST_IDLE : ST_DATA2;
      end
      ST_DATA2: begin
        DV   = 1'b1;
        DATA = {1'b0, d2_q};
        if (take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  register_clr #(.W(8)) u_status (
    .clk(CLK), .clr(RST), .en(accept), .d(req_status), .q(status_q)
  );

  register_clr #(.W(7)) u_d1 (
    .clk(CLK), .clr(RST), .en(accept), .d(req_d1), .q(d1_q)
  );

  register_clr #(.W(7)) u_d2 (
    .clk(CLK), .clr(RST), .en(accept), .d(NOTE_VEL), .q(d2_q)
  );

  // Cleared to 8'h00 (never a valid status) so the first message after reset carries status.
  register_clr #(.W(8)) u_last_status (
    .clk(CLK), .clr(RST), .en(last_en), .d(status_q), .q(last_status_q)
  );

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx with running status on and off.
module tb_midi_tx;

  logic       CLK = 1'b0;
  logic       RST, CE, TX_READY;
  logic [3:0] CHANNEL;
  logic [6:0] NOTE_NUM, NOTE_VEL, PROGRAM;
  logic       SEND_NOTE_ON, SEND_NOTE_OFF, SEND_PROG;
  logic       ready_rs, dv_rs, ready_nr, dv_nr;
  logic [7:0] data_rs, data_nr;

  always #5 CLK = ~CLK;

  midi_tx #(.RUNNING_STATUS(1'b1)) dut_rs (
    .CLK(CLK), .RST(RST), .CE(CE), .CHANNEL(CHANNEL), .NOTE_NUM(NOTE_NUM),
    .NOTE_VEL(NOTE_VEL), .PROGRAM(PROGRAM), .SEND_NOTE_ON(SEND_NOTE_ON),
    .SEND_NOTE_OFF(SEND_NOTE_OFF), .SEND_PROG(SEND_PROG), .READY(ready_rs),
    .DATA(data_rs), .DV(dv_rs), .TX_READY(TX_READY)
  );

  midi_tx #(.RUNNING_STATUS(1'b0)) dut_nr (
    .CLK(CLK), .RST(RST), .CE(CE), .CHANNEL(CHANNEL), .NOTE_NUM(NOTE_NUM),
    .NOTE_VEL(NOTE_VEL), .PROGRAM(PROGRAM), .SEND_NOTE_ON(SEND_NOTE_ON),
    .SEND_NOTE_OFF(SEND_NOTE_OFF), .SEND_PROG(SEND_PROG), .READY(ready_nr),
    .DATA(data_nr), .DV(dv_nr), .TX_READY(TX_READY)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] got_rs[$], got_nr[$], exp_rs[$], exp_nr[$];
  int         st_nr[$];
  logic [7:0] last_rs = 8'h00;
  logic       rand_bp = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Inputs settle 1 time unit after each rising edge, so at the falling edge these
  // values describe exactly the transfer the next rising edge will perform.
  always @(negedge CLK) begin
    if (!RST && CE && TX_READY) begin
      if (dv_rs) got_rs.push_back(data_rs);
      if (dv_nr) begin
        got_nr.push_back(data_nr);
        st_nr.push_back(cyc);
      end
    end
  end

  // Message-level model: one request becomes its MIDI byte list for each variant.
  task automatic model_req(input logic [2:0] sends, input logic [3:0] ch,
                           input logic [6:0] num, input logic [6:0] vel, input logic [6:0] prog);
    logic [7:0] st;
    logic [6:0] d1;
    bit         is_prog;
    if (sends[2])      begin st = {4'h8, ch}; d1 = num;  is_prog = 0; end
    else if (sends[1]) begin st = {4'h9, ch}; d1 = num;  is_prog = 0; end
    else if (sends[0]) begin st = {4'hC, ch}; d1 = prog; is_prog = 1; end
    else return;
    exp_nr.push_back(st);
    if (st != last_rs) exp_rs.push_back(st);
    last_rs = st;
    exp_nr.push_back({1'b0, d1});
    exp_rs.push_back({1'b0, d1});
    if (!is_prog) begin
      exp_nr.push_back({1'b0, vel});
      exp_rs.push_back({1'b0, vel});
    end
  endtask

  // sends = {note_off, note_on, prog}
  task automatic send_req(input logic [2:0] sends, input logic [3:0] ch,
                          input logic [6:0] num, input logic [6:0] vel, input logic [6:0] prog);
    @(posedge CLK); #1;
    CE = 1'b1;
    CHANNEL = ch; NOTE_NUM = num; NOTE_VEL = vel; PROGRAM = prog;
    SEND_NOTE_OFF = sends[2]; SEND_NOTE_ON = sends[1]; SEND_PROG = sends[0];
    model_req(sends, ch, num, vel, prog);
    @(posedge CLK); #1;
    SEND_NOTE_OFF = 1'b0; SEND_NOTE_ON = 1'b0; SEND_PROG = 1'b0;
    CHANNEL = 4'($urandom); NOTE_NUM = 7'($urandom); NOTE_VEL = 7'($urandom); PROGRAM = 7'($urandom);
  endtask

  task automatic wait_idle(output int n_rs, output int n_nr);
    n_rs = -1;
    n_nr = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (n_rs < 0 && ready_rs) n_rs = n;
      if (n_nr < 0 && ready_nr) n_nr = n;
      if (n_rs >= 0 && n_nr >= 0) break;
      @(posedge CLK); #1;
      if (rand_bp) begin
        TX_READY = 1'($urandom_range(0, 1));
        CE = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic clear_streams();
    got_rs.delete(); got_nr.delete(); exp_rs.delete(); exp_nr.delete(); st_nr.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; TX_READY = 1'b1;
    CHANNEL = 4'd0; NOTE_NUM = 7'd0; NOTE_VEL = 7'd0; PROGRAM = 7'd0;
    SEND_NOTE_ON = 1'b1; SEND_NOTE_OFF = 1'b0; SEND_PROG = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0; SEND_NOTE_ON = 1'b0;
    @(negedge CLK);
    checks++; if (ready_rs !== 1'b1 || ready_nr !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b want 1", ready_rs, ready_nr); end
    checks++; if (dv_rs !== 1'b0 || dv_nr !== 1'b0) begin errors++; $display("FAIL reset_dv got %b/%b want 0", dv_rs, dv_nr); end
    checks++; if (data_rs !== 8'h00 || data_nr !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h want 00", data_rs, data_nr); end
    repeat (4) @(negedge CLK);
    checks++; if (got_rs.size() != 0 || got_nr.size() != 0) begin errors++; $display("FAIL reset_priority got %p/%p want empty", got_rs, got_nr); end
    clear_streams();
  endtask

  task automatic test_note_on();
    int n_rs, n_nr;
    logic [7:0] want[$];
    want = {8'h93, 8'h3C, 8'h64};
    send_req(3'b010, 4'd3, 7'd60, 7'd100, 7'd0);
    wait_idle(n_rs, n_nr);
    checks++; if (n_nr !== 4 || n_rs !== 4) begin errors++; $display("FAIL t1_ready_latency got %0d/%0d want 4", n_rs, n_nr); end
    checks++; if (got_nr != want) begin errors++; $display("FAIL t1_bytes got %p want %p", got_nr, want); end
    checks++; if (st_nr.size() != 3 || st_nr[2] - st_nr[0] != 2) begin errors++; $display("FAIL t1_consecutive got %p want 3 consecutive", st_nr); end
    checks++; if (got_rs != exp_rs) begin errors++; $display("FAIL t1_rs_stream got %p want %p", got_rs, exp_rs); end
    clear_streams();
  endtask

  task automatic test_running_status();
    int n_rs, n_nr;
    logic [7:0] want[$];
    want = {8'h90, 8'h28, 8'h01, 8'h29, 8'h02};
    send_req(3'b010, 4'd0, 7'd40, 7'd1, 7'd0);
    wait_idle(n_rs, n_nr);
    send_req(3'b010, 4'd0, 7'd41, 7'd2, 7'd0);
    wait_idle(n_rs, n_nr);
    checks++; if (n_rs !== 3 || n_nr !== 4) begin errors++; $display("FAIL t2_latency got %0d/%0d want 3/4", n_rs, n_nr); end
    checks++; if (got_rs != want) begin errors++; $display("FAIL t2_rs_bytes got %p want %p", got_rs, want); end
    checks++; if (got_nr != exp_nr) begin errors++; $display("FAIL t2_nr_stream got %p want %p", got_nr, exp_nr); end
    clear_streams();
  endtask

  task automatic test_prog_then_note();
    int n_rs, n_nr;
    send_req(3'b001, 4'd2, 7'd0, 7'd0, 7'd5);
    wait_idle(n_rs, n_nr);
    checks++; if (n_rs !== 3 || n_nr !== 3) begin errors++; $display("FAIL t3_prog_latency got %0d/%0d want 3", n_rs, n_nr); end
    send_req(3'b010, 4'd2, 7'($urandom), 7'($urandom), 7'd0);
    wait_idle(n_rs, n_nr);
    checks++; if (got_rs.size() != 5 || got_rs[0] !== 8'hC2 || got_rs[1] !== 8'h05 || got_rs[2] !== 8'h92) begin
      errors++; $display("FAIL t3_rs_head got %p want C2,05,92,..", got_rs); end
    checks++; if (got_rs != exp_rs || got_nr != exp_nr) begin errors++; $display("FAIL t3_streams got %p/%p want %p/%p", got_rs, got_nr, exp_rs, exp_nr); end
    clear_streams();
  endtask

  task automatic test_backpressure();
    int n_rs, n_nr;
    logic [7:0] want[$];
    want = {8'h97, 8'h21, 8'h00};
    send_req(3'b010, 4'd7, 7'd33, 7'd0, 7'd0);
    @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      TX_READY = (i >= 5);
      CE = (i < 5);
      @(negedge CLK);
      checks++; if (dv_nr !== 1'b1 || data_nr !== 8'h21 || dv_rs !== 1'b1 || data_rs !== 8'h21) begin
        errors++; $display("FAIL t4_hold[%0d] got %b:%h/%b:%h want 1:21", i, dv_rs, data_rs, dv_nr, data_nr); end
      @(posedge CLK); #1;
    end
    TX_READY = 1'b1; CE = 1'b1;
    wait_idle(n_rs, n_nr);
    checks++; if (n_rs < 0 || n_nr < 0) begin errors++; $display("FAIL t4_timeout got %0d/%0d want done", n_rs, n_nr); end
    checks++; if (got_nr != want || got_rs != exp_rs) begin errors++; $display("FAIL t4_streams got %p/%p want %p/%p", got_nr, got_rs, want, exp_rs); end
    clear_streams();
  endtask

  task automatic test_priority_busy();
    int n_rs, n_nr;
    send_req(3'b101, 4'd5, 7'($urandom), 7'($urandom), 7'($urandom));
    SEND_NOTE_ON = 1'b1; CHANNEL = 4'd9;
    @(posedge CLK); #1;
    SEND_NOTE_ON = 1'b0;
    wait_idle(n_rs, n_nr);
    checks++; if (n_rs < 0 || n_nr < 0) begin errors++; $display("FAIL t5_timeout got %0d/%0d want done", n_rs, n_nr); end
    checks++; if (got_nr.size() != 3 || got_nr[0] !== 8'h85) begin errors++; $display("FAIL t5_off_only got %p want 85,kk,vv", got_nr); end
    checks++; if (got_rs != exp_rs || got_nr != exp_nr) begin errors++; $display("FAIL t5_streams got %p/%p want %p/%p", got_rs, got_nr, exp_rs, exp_nr); end
    repeat (4) @(negedge CLK);
    checks++; if (got_nr.size() != 3 || ready_nr !== 1'b1) begin errors++; $display("FAIL t5_ignored got %0d bytes ready %b want 3 bytes ready 1", got_nr.size(), ready_nr); end
    clear_streams();
  endtask

  task automatic test_reset_mid();
    int n_rs, n_nr;
    logic [7:0] want[$];
    want = {8'h91, 8'h32, 8'h46};
    send_req(3'b010, 4'd1, 7'd50, 7'd70, 7'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (dv_rs !== 1'b0 || ready_rs !== 1'b1 || dv_nr !== 1'b0) begin errors++; $display("FAIL t6_abandon got dv %b ready %b want dv 0 ready 1", dv_rs, ready_rs); end
    checks++; if (got_rs.size() != 1 || got_rs[0] !== 8'h91) begin errors++; $display("FAIL t6_partial got %p want 91", got_rs); end
    clear_streams();
    last_rs = 8'h00;
    send_req(3'b010, 4'd1, 7'd50, 7'd70, 7'd0);
    wait_idle(n_rs, n_nr);
    checks++; if (got_rs != want || n_rs !== 4) begin errors++; $display("FAIL t6_resend got %p n=%0d want %p n=4", got_rs, n_rs, want); end
    clear_streams();
  endtask

  task automatic test_random();
    int n_rs, n_nr;
    rand_bp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_req(3'($urandom_range(1, 7)), 4'($urandom_range(0, 1)), 7'($urandom), 7'($urandom), 7'($urandom));
      wait_idle(n_rs, n_nr);
      checks++; if (n_rs < 0 || n_nr < 0) begin errors++; $display("FAIL rnd_timeout[%0d] got %0d/%0d want done", k, n_rs, n_nr); end
      checks++; if (got_rs != exp_rs) begin errors++; $display("FAIL rnd_rs[%0d] got %p want %p", k, got_rs, exp_rs); end
      checks++; if (got_nr != exp_nr) begin errors++; $display("FAIL rnd_nr[%0d] got %p want %p", k, got_nr, exp_nr); end
      clear_streams();
    end
    rand_bp = 1'b0;
    TX_READY = 1'b1;
    CE = 1'b1;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_prog_then_note();
    test_backpressure();
    test_priority_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
